pay_gate_ctrl: RTL

PAY_GATE_CTRL -- requirements
Module: pay_gate_ctrl

---
 rtl/pay_gate_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pay_gate_ctrl.sv
// Pay-per-passage gate controller: collects coins after a ticket is inserted,
// opens the gate once the price is met, and refunds credited coins on cancel or
// inactivity timeout. Moore machine; all outputs come from registers.
module pay_gate_ctrl #(
   parameter int unsigned PRICE          = 2,
   parameter int unsigned GATE_CYCLES    = 8,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic       clk,
   input  logic       R_n,
   input  logic       iT,
   input  logic       iM,
   input  logic       iC,
   output logic       T,
   output logic       V,
   output logic [3:0] D,
   output logic       RF,
   output logic       BUSY
);

   localparam int unsigned GW = $clog2(GATE_CYCLES + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [3:0]    PRICE_C   = 4'(PRICE);
   localparam logic [GW-1:0] GATE_C    = GW'(GATE_CYCLES);
   localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      StIdle,
      StCollect,
      StGate,
      StRefund
   } state_e;

   state_e        state_q, state_d;
   logic [3:0]    credit_q, credit_d;
   logic [TW-1:0] idle_q, idle_d, idle_inc;
   logic [GW-1:0] gate_q, gate_d;

   // Coin credit is the counter register itself.
   assign D = credit_q;

   // Next-state and counter updates.
   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      idle_d   = idle_q;
      gate_d   = gate_q;
      idle_inc = idle_q + TW'(1);
      case (state_q)
         StIdle: begin
            credit_d = 4'd0;
            idle_d   = '0;
            gate_d   = '0;
            if (iT) begin
               state_d = StCollect;
            end
         end
         StCollect: begin
            if (iM) begin
               // Coin is credited before a same-cycle cancel is considered.
               credit_d = credit_q + 4'd1;
               idle_d   = '0;
               if (credit_q == PRICE_C - 4'd1) begin
                  state_d = StGate;
                  gate_d  = GATE_C;
               end else if (iC) begin
                  state_d = StRefund;
               end
            end else begin
               idle_d = idle_inc;
               if (iC || (idle_inc == TIMEOUT_C)) begin
                  idle_d  = '0;
                  state_d = (credit_q != 4'd0) ? StRefund : StIdle;
               end
            end
         end
         StGate: begin
            if (gate_q <= GW'(1)) begin
               state_d  = StIdle;
               credit_d = 4'd0;
               gate_d   = '0;
            end else begin
               gate_d = gate_q - GW'(1);
            end
         end
         StRefund: begin
            // One coin returned per cycle; a final cycle at zero credit precedes idle.
            if (credit_q != 4'd0) begin
               credit_d = credit_q - 4'd1;
            end else begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d  = StIdle;
            credit_d = 4'd0;
            idle_d   = '0;
            gate_d   = '0;
         end
      endcase
   end

   // State, counters and registered outputs; reset discards credit silently.
   always_ff @(posedge clk or negedge R_n) begin
      if (!R_n) begin
         state_q  <= StIdle;
         credit_q <= 4'd0;
         idle_q   <= '0;
         gate_q   <= '0;
         T        <= 1'b0;
         V        <= 1'b0;
         RF       <= 1'b0;
         BUSY     <= 1'b0;
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         idle_q   <= idle_d;
         gate_q   <= gate_d;
         T        <= (state_d != StIdle);
         BUSY     <= (state_d != StIdle);
         V        <= (state_d == StGate);
         RF       <= (state_d == StRefund) && (credit_d != 4'd0);
      end
   end

endmodule
